// File: rtl/sram_cnt_pkg.sv
// Shared types and default widths for the pixel hit-counter SRAM controller.
// No logic. No latency. No backpressure.
// Holds the FSM state encoding and the operation tag used by controller and bench.
package sram_cnt_pkg;

  localparam int ADDR_BITS_DEF = 6;
  localparam int DATA_BITS_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    PRE_R,
    WR,
    PRE_W
  } state_e;

  typedef enum logic {
    OP_INC,
    OP_RO
  } op_e;

endpackage

// File: rtl/sram_cnt_arb.sv
// Two-way round-robin arbiter: bit 0 = increment path, bit 1 = readout path.
// Latency: combinational grant; the last-winner flag updates on the grant edge.
// Backpressure: no grant while grant_en is low; a loser keeps requesting.
module sram_cnt_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_ro;

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) gnt = last_ro ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Starting with "readout won last" lets the hit path win the first contention.
  always_ff @(posedge clk) begin
    if (rst)       last_ro <= 1'b1;
    else if (|gnt) last_ro <= gnt[1];
  end

endmodule

// File: rtl/sram_cnt_ctrl.sv
// Sole access controller for a 64x12 handshake SRAM of per-pixel hit counters.
// Latency: plain readout ack 3 cycles after grant, increment/clear ack 6 cycles.
// Backpressure: requesters hold req until ack; grants only happen from IDLE.
module sram_cnt_ctrl
  import sram_cnt_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int PULSE_CYC = 1,
  parameter int PRE_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_req,
  input  logic [ADDR_BITS-1:0] inc_addr,
  output logic                 inc_ack,
  input  logic                 ro_req,
  input  logic [ADDR_BITS-1:0] ro_addr,
  input  logic                 ro_clr,
  output logic                 ro_ack,
  output logic                 ro_valid,
  output logic [DATA_BITS-1:0] ro_data,
  output logic                 sram_read,
  output logic                 sram_write,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_din,
  input  logic [DATA_BITS-1:0] sram_dout,
  input  logic                 sram_read_done,
  input  logic                 sram_write_done,
  output logic                 busy,
  output logic                 sat_evt
);

  localparam int CNT_W = 8;

  state_e               state, state_nxt;
  op_e                  op_q, op_d;
  logic                 clr_q, clr_d, op_vld, vld_d;
  logic [DATA_BITS-1:0] val_q, val_d, val_inc;
  logic [CNT_W-1:0]     cnt, cnt_d, cnt_lim;
  logic                 cnt_ok;
  logic [1:0]           gnt;

  logic                 read_d, write_d, inc_ack_d, ro_ack_d, ro_valid_d, sat_d, busy_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [DATA_BITS-1:0] din_d, ro_data_d;

  sram_cnt_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({ro_req, inc_req}),
    .grant_en (state == IDLE),
    .gnt      (gnt)
  );

  // One counter serves both strobe hold time and precharge; it restarts on every state change.
  assign cnt_lim = (state == RD || state == WR) ? CNT_W'(PULSE_CYC) : CNT_W'(PRE_CYC);
  assign cnt_ok  = (cnt + CNT_W'(1)) >= cnt_lim;
  assign val_inc = (&val_q) ? val_q : val_q + DATA_BITS'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = RD;
      RD:      if (cnt_ok && sram_read_done) state_nxt = PRE_R;
      PRE_R:   if (cnt_ok) state_nxt = (op_q == OP_INC || clr_q) ? WR : IDLE;
      WR:      if (cnt_ok && sram_write_done) state_nxt = PRE_W;
      PRE_W:   if (cnt_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_d     = 1'b0;
    write_d    = 1'b0;
    addr_d     = sram_addr;
    din_d      = sram_din;
    op_d       = op_q;
    clr_d      = clr_q;
    vld_d      = op_vld;
    val_d      = val_q;
    ro_data_d  = ro_data;
    ro_valid_d = 1'b0;
    inc_ack_d  = 1'b0;
    ro_ack_d   = 1'b0;
    sat_d      = 1'b0;
    busy_d     = (state_nxt != IDLE);
    cnt_d      = (state_nxt != state) ? '0 : (cnt_ok ? cnt : cnt + CNT_W'(1));
    case (state)
      IDLE: begin
        if (|gnt) begin
          read_d = 1'b1;
          op_d   = gnt[1] ? OP_RO : OP_INC;
          clr_d  = gnt[1] & ro_clr;
          addr_d = gnt[1] ? ro_addr : inc_addr;
          vld_d  = 1'b1;
        end
      end
      RD: begin
        if (state_nxt == PRE_R) begin
          val_d = sram_dout;
          if (op_q == OP_RO) begin
            ro_data_d  = sram_dout;
            ro_valid_d = 1'b1;
          end
        end else begin
          read_d = 1'b1;
        end
      end
      PRE_R: begin
        if (state_nxt == WR) begin
          write_d = 1'b1;
          din_d   = (op_q == OP_INC) ? val_inc : '0;
          sat_d   = (op_q == OP_INC) && (&val_q);
        end else if (state_nxt == IDLE) begin
          ro_ack_d = op_vld;
        end
      end
      WR: begin
        if (state_nxt == WR) write_d = 1'b1;
      end
      PRE_W: begin
        // op_vld stays low after reset so the post-reset precharge never acks.
        if (state_nxt == IDLE) begin
          inc_ack_d = op_vld && (op_q == OP_INC);
          ro_ack_d  = op_vld && (op_q == OP_RO);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRE_W;
      cnt        <= '0;
      op_q       <= OP_INC;
      clr_q      <= 1'b0;
      op_vld     <= 1'b0;
      val_q      <= '0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
      ro_data    <= '0;
      ro_valid   <= 1'b0;
      inc_ack    <= 1'b0;
      ro_ack     <= 1'b0;
      sat_evt    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_d;
      op_q       <= op_d;
      clr_q      <= clr_d;
      op_vld     <= vld_d;
      val_q      <= val_d;
      sram_read  <= read_d;
      sram_write <= write_d;
      sram_addr  <= addr_d;
      sram_din   <= din_d;
      ro_data    <= ro_data_d;
      ro_valid   <= ro_valid_d;
      inc_ack    <= inc_ack_d;
      ro_ack     <= ro_ack_d;
      sat_evt    <= sat_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_cnt_ctrl.sv
// Directed bench for sram_cnt_ctrl with a behavioural handshake SRAM and result scoreboard.
module tb_sram_cnt_ctrl;

  localparam int PRE_CYC = 1;

  logic        clk, rst;
  logic        inc_req, inc_ack, ro_req, ro_clr, ro_ack, ro_valid;
  logic [5:0]  inc_addr, ro_addr, sram_addr;
  logic [11:0] ro_data, sram_din, sram_dout;
  logic        sram_read, sram_write, sram_read_done, sram_write_done;
  logic        busy, sat_evt;

  logic [11:0] mem   [64];
  logic [11:0] model [64];
  logic [11:0] exp_data [$];
  logic [1:0]  exp_ack  [$];

  int checks = 0;
  int errors = 0;
  int sat_cnt = 0;

  sram_cnt_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inc_req         (inc_req),
    .inc_addr        (inc_addr),
    .inc_ack         (inc_ack),
    .ro_req          (ro_req),
    .ro_addr         (ro_addr),
    .ro_clr          (ro_clr),
    .ro_ack          (ro_ack),
    .ro_valid        (ro_valid),
    .ro_data         (ro_data),
    .sram_read       (sram_read),
    .sram_write      (sram_write),
    .sram_addr       (sram_addr),
    .sram_din        (sram_din),
    .sram_dout       (sram_dout),
    .sram_read_done  (sram_read_done),
    .sram_write_done (sram_write_done),
    .busy            (busy),
    .sat_evt         (sat_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: done answers one cycle after the strobe is seen, write commits once per pulse.
  always @(posedge clk) begin
    sram_read_done  <= sram_read;
    sram_write_done <= sram_write;
    if (sram_read) sram_dout <= mem[sram_addr];
    if (sram_write && !sram_write_done) mem[sram_addr] <= sram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic        prev_strobe = 1'b0, prev_write = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [11:0] prev_din = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_read || sram_write) chk("one_strobe", {31'd0, sram_read & sram_write}, 32'd0);
      if ((sram_read || sram_write) && prev_strobe) chk("addr_stable", {26'd0, sram_addr}, {26'd0, prev_addr});
      if (sram_write && prev_write) chk("din_stable", {20'd0, sram_din}, {20'd0, prev_din});
      if (ro_valid) begin
        if (exp_data.size() == 0) chk("ro_valid_unexpected", 32'd1, 32'd0);
        else chk("ro_data", {20'd0, ro_data}, {20'd0, exp_data.pop_front()});
      end
      if (inc_ack || ro_ack) begin
        if (exp_ack.size() == 0) chk("ack_unexpected", {30'd0, ro_ack, inc_ack}, 32'd0);
        else chk("ack_kind", {30'd0, ro_ack, inc_ack}, {30'd0, exp_ack.pop_front()});
      end
      if (sat_evt) sat_cnt++;
    end
    prev_strobe = sram_read | sram_write;
    prev_write  = sram_write;
    prev_addr   = sram_addr;
    prev_din    = sram_din;
  end

  // Drive one request, record expectations from the bench model, wait for its ack and check latency.
  task automatic do_op(input bit is_ro, input logic [5:0] a, input bit clr, input int exp_lat);
    int n;
    bit got;
    @(negedge clk);
    n = 0;
    got = 1'b0;
    if (is_ro) begin
      ro_addr = a; ro_clr = clr; ro_req = 1'b1;
      exp_data.push_back(model[a]);
      if (clr) model[a] = 12'h000;
      exp_ack.push_back(2'b10);
    end else begin
      inc_addr = a; inc_req = 1'b1;
      model[a] = (model[a] == 12'hFFF) ? 12'hFFF : model[a] + 12'h001;
      exp_ack.push_back(2'b01);
    end
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = is_ro ? ro_ack : inc_ack;
    end
    chk(is_ro ? "ro_timeout" : "inc_timeout", {31'd0, got}, 32'd1);
    chk(is_ro ? "ro_latency" : "inc_latency", n - 1, exp_lat);
    inc_req = 1'b0;
    ro_req  = 1'b0;
  endtask

  initial begin
    int n, inc_left, ro_left, s0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 12'h000;
      model[i] = 12'h000;
    end
    rst = 1'b1; inc_req = 1'b0; ro_req = 1'b0; ro_clr = 1'b0;
    inc_addr = '0; ro_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_read",  {31'd0, sram_read}, 32'd0);
    chk("rst_write", {31'd0, sram_write}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_pulses", {28'd0, inc_ack, ro_ack, ro_valid, sat_evt}, 32'd0);
    chk("rst_addr",  {26'd0, sram_addr}, 32'd0);
    chk("rst_din",   {20'd0, sram_din}, 32'd0);
    chk("rst_ro_data", {20'd0, ro_data}, 32'd0);
    mem[5] = 12'h00A; model[5] = 12'h00A;
    mem[7] = 12'hFFF; model[7] = 12'hFFF;
    rst = 1'b0;

    // Plain readout leaves memory alone.
    do_op(1'b1, 6'd5, 1'b0, 3);
    chk("t1_mem_unchanged", {20'd0, mem[5]}, 32'h00A);

    // Three increments, then read back.
    repeat (3) do_op(1'b0, 6'd5, 1'b0, 6);
    chk("t2_mem", {20'd0, mem[5]}, 32'h00D);
    chk("t2_no_sat", sat_cnt, 0);
    do_op(1'b1, 6'd5, 1'b0, 3);

    // Saturating increment still writes, flags sat_evt.
    s0 = sat_cnt;
    do_op(1'b0, 6'd7, 1'b0, 6);
    chk("t3_sat_evt", sat_cnt - s0, 1);
    do_op(1'b1, 6'd7, 1'b0, 3);

    // Read-and-clear, then confirm the counter is zero.
    do_op(1'b1, 6'd5, 1'b1, 6);
    chk("t4_mem_cleared", {20'd0, mem[5]}, 32'h000);
    do_op(1'b1, 6'd5, 1'b0, 3);

    // Contention: both requesters held at addr 9; grants must alternate inc,ro,inc,ro.
    exp_ack.push_back(2'b01); exp_ack.push_back(2'b10);
    exp_ack.push_back(2'b01); exp_ack.push_back(2'b10);
    exp_data.push_back(12'h001); exp_data.push_back(12'h002);
    model[9] = 12'h002;
    @(negedge clk);
    inc_addr = 6'd9; ro_addr = 6'd9; ro_clr = 1'b0;
    inc_left = 2; ro_left = 2; n = 0;
    inc_req = 1'b1; ro_req = 1'b1;
    while ((inc_left > 0 || ro_left > 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (inc_ack) inc_left--;
      if (ro_ack) ro_left--;
      inc_req = (inc_left > 0);
      ro_req  = (ro_left > 0);
    end
    chk("t5_ops_done", inc_left + ro_left, 0);
    chk("t5_mem", {20'd0, mem[9]}, 32'h002);

    // Reset in the middle of a write: strobe drops, op abandoned, precharge before next strobe.
    @(negedge clk);
    inc_addr = 6'd20; inc_req = 1'b1; n = 0;
    while (!sram_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_write", {31'd0, sram_write}, 32'd1);
    rst = 1'b1; inc_req = 1'b0;
    @(negedge clk);
    chk("t6_strobes_low", {30'd0, sram_read, sram_write}, 32'd0);
    chk("t6_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t6_no_ack", {30'd0, inc_ack, ro_ack}, 32'd0);
    rst = 1'b0;
    ro_addr = 6'd5; ro_clr = 1'b0; ro_req = 1'b1;
    exp_data.push_back(model[5]);
    exp_ack.push_back(2'b10);
    n = 0;
    while (!sram_read && !sram_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_strobe_seen", {31'd0, sram_read}, 32'd1);
    chk("t6_precharge_gap", {31'd0, n > PRE_CYC}, 32'd1);
    n = 0;
    while (!ro_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_ro_after_reset", {31'd0, ro_ack}, 32'd1);
    ro_req = 1'b0;

    repeat (5) @(negedge clk);
    chk("final_data_queue_empty", exp_data.size(), 0);
    chk("final_ack_queue_empty", exp_ack.size(), 0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
